ycbcr_skin_bbox: RTL and testbench

Downstream consumer of the RGB-to-YCbCr stage. Classifies each active pixel as skin or non-skin using Cb/Cr window thresholds and outputs a registered binary video stream with delayed syncs. Accumulates per-frame skin statistics (bounding box, pixel count) and publishes them once per frame for the overlay/tracking logic.

---
 rtl/ycbcr_pkg.sv | 24 ++
 rtl/ycbcr_skin_bbox_if.sv | 38 +++
 rtl/ycbcr_skin_bbox_skin_classifier.sv | 20 ++
 rtl/ycbcr_skin_bbox.sv | 195 +++++++++++++++++++
 tb/tb_ycbcr_skin_bbox.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/ycbcr_pkg.sv
// Shared constants and state encoding for the YCbCr colour-segmentation stages.
package ycbcr_pkg;

   localparam int CW_DEF      = 11;
   localparam int CB_MIN_DEF  = 77;
   localparam int CB_MAX_DEF  = 127;
   localparam int CR_MIN_DEF  = 133;
   localparam int CR_MAX_DEF  = 173;
   localparam int MIN_PIX_DEF = 64;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCUM   = 2'd1,
      PUBLISH = 2'd2
   } bbox_state_t;

   // Inclusive unsigned window test.
   function automatic logic in_window(input logic [7:0] v,
                                      input logic [7:0] lo,
                                      input logic [7:0] hi);
      return (v >= lo) && (v <= hi);
   endfunction

endpackage

// File: rtl/ycbcr_skin_bbox_if.sv
// Video-in, binary video-out and per-frame box statistics of the skin bbox block.
interface ycbcr_skin_bbox_if #(
   parameter int CW = 11
);
   logic            pre_frame_vsync;
   logic            pre_frame_hsync;
   logic            pre_frame_de;
   logic [7:0]      img_y;
   logic [7:0]      img_cb;
   logic [7:0]      img_cr;

   logic            post_frame_vsync;
   logic            post_frame_hsync;
   logic            post_frame_de;
   logic [7:0]      bin_pixel;

   logic [CW-1:0]   box_x_min;
   logic [CW-1:0]   box_x_max;
   logic [CW-1:0]   box_y_min;
   logic [CW-1:0]   box_y_max;
   logic [2*CW-1:0] box_pix_cnt;
   logic            box_valid;
   logic            frame_done;

   // Source of the video stream / consumer of the results.
   modport master (
      output pre_frame_vsync, pre_frame_hsync, pre_frame_de, img_y, img_cb, img_cr,
      input  post_frame_vsync, post_frame_hsync, post_frame_de, bin_pixel,
      input  box_x_min, box_x_max, box_y_min, box_y_max, box_pix_cnt, box_valid, frame_done
   );

   // The skin bbox block itself.
   modport slave (
      input  pre_frame_vsync, pre_frame_hsync, pre_frame_de, img_y, img_cb, img_cr,
      output post_frame_vsync, post_frame_hsync, post_frame_de, bin_pixel,
      output box_x_min, box_x_max, box_y_min, box_y_max, box_pix_cnt, box_valid, frame_done
   );
endinterface

// File: rtl/ycbcr_skin_bbox_skin_classifier.sv
// Combinational Cb/Cr window compare; skin only counts on active pixels.
module skin_classifier
   import ycbcr_pkg::*;
#(
   parameter int CB_MIN = CB_MIN_DEF,
   parameter int CB_MAX = CB_MAX_DEF,
   parameter int CR_MIN = CR_MIN_DEF,
   parameter int CR_MAX = CR_MAX_DEF
) (
   input  logic       de,
   input  logic [7:0] cb,
   input  logic [7:0] cr,
   output logic       skin
);

   assign skin = de
               & in_window(cb, 8'(CB_MIN), 8'(CB_MAX))
               & in_window(cr, 8'(CR_MIN), 8'(CR_MAX));

endmodule

// File: rtl/ycbcr_skin_bbox.sv
// Skin segmentation with per-frame bounding box / pixel count statistics.
//
// state   | meaning
// IDLE    | after reset, no frame boundary seen yet; nothing to publish
// ACCUM   | accumulating the current frame
// PUBLISH | one cycle: snapshot of the finished frame goes to the box outputs
module ycbcr_skin_bbox
   import ycbcr_pkg::*;
#(
   parameter int CB_MIN  = CB_MIN_DEF,
   parameter int CB_MAX  = CB_MAX_DEF,
   parameter int CR_MIN  = CR_MIN_DEF,
   parameter int CR_MAX  = CR_MAX_DEF,
   parameter int CW      = CW_DEF,
   parameter int MIN_PIX = MIN_PIX_DEF
) (
   input logic               clk,
   input logic               rst_n,
   ycbcr_skin_bbox_if.slave  vid
);

   localparam logic [CW-1:0]   C_MAX     = '1;
   localparam logic [2*CW-1:0] P_MAX     = '1;
   localparam logic [2*CW-1:0] MIN_PIX_W = (2*CW)'(MIN_PIX);

   logic            skin;
   logic            vs_q, hs_q, de_q;
   logic [7:0]      bin_q;
   logic            vs_rise, de_fall, frame_seen, publish;
   logic [CW-1:0]   x_cnt, y_cnt, y_pix;
   logic [CW-1:0]   x_min, x_max, y_min, y_max;
   logic [CW-1:0]   base_x_min, base_x_max, base_y_min, base_y_max;
   logic [2*CW-1:0] pix_acc, base_cnt;
   logic [CW-1:0]   snap_x_min, snap_x_max, snap_y_min, snap_y_max;
   logic [2*CW-1:0] snap_cnt;
   bbox_state_t     state_q, state_d;
   logic            unused_luma;

   assign unused_luma = ^vid.img_y;

   skin_classifier #(
      .CB_MIN(CB_MIN), .CB_MAX(CB_MAX), .CR_MIN(CR_MIN), .CR_MAX(CR_MAX)
   ) u_classifier (
      .de   (vid.pre_frame_de),
      .cb   (vid.img_cb),
      .cr   (vid.img_cr),
      .skin (skin)
   );

   assign vs_rise    = vid.pre_frame_vsync & ~vs_q;
   assign de_fall    = de_q & ~vid.pre_frame_de;
   assign frame_seen = (state_q != IDLE);
   // A pixel coinciding with the vsync rise already belongs to line 0 of the new frame.
   assign y_pix      = vs_rise ? '0 : y_cnt;

   // Video path: syncs and binary pixel registered together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_q  <= 1'b0;
         hs_q  <= 1'b0;
         de_q  <= 1'b0;
         bin_q <= 8'd0;
      end else begin
         vs_q  <= vid.pre_frame_vsync;
         hs_q  <= vid.pre_frame_hsync;
         de_q  <= vid.pre_frame_de;
         bin_q <= skin ? 8'd255 : 8'd0;
      end
   end

   assign vid.post_frame_vsync = vs_q;
   assign vid.post_frame_hsync = hs_q;
   assign vid.post_frame_de    = de_q;
   assign vid.bin_pixel        = bin_q;

   // Saturating pixel/line coordinate counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_cnt <= '0;
         y_cnt <= '0;
      end else begin
         if (de_fall)
            x_cnt <= '0;
         else if (vid.pre_frame_de && (x_cnt != C_MAX))
            x_cnt <= x_cnt + 1'b1;

         if (vs_rise)
            y_cnt <= '0;
         else if (de_fall && (y_cnt != C_MAX))
            y_cnt <= y_cnt + 1'b1;
      end
   end

   // Accumulator base: freshly initialised on frame start, else running values.
   always_comb begin
      base_x_min = x_min;
      base_x_max = x_max;
      base_y_min = y_min;
      base_y_max = y_max;
      base_cnt   = pix_acc;
      if (vs_rise) begin
         base_x_min = '1;
         base_x_max = '0;
         base_y_min = '1;
         base_y_max = '0;
         base_cnt   = '0;
      end
   end

   // Frame accumulators; the finished frame is snapshotted at the vsync rise so the
   // accumulators can restart immediately while publishing happens a cycle later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_min      <= '0;
         x_max      <= '0;
         y_min      <= '0;
         y_max      <= '0;
         pix_acc    <= '0;
         snap_x_min <= '0;
         snap_x_max <= '0;
         snap_y_min <= '0;
         snap_y_max <= '0;
         snap_cnt   <= '0;
      end else begin
         x_min   <= (skin && (x_cnt < base_x_min)) ? x_cnt : base_x_min;
         x_max   <= (skin && (x_cnt > base_x_max)) ? x_cnt : base_x_max;
         y_min   <= (skin && (y_pix < base_y_min)) ? y_pix : base_y_min;
         y_max   <= (skin && (y_pix > base_y_max)) ? y_pix : base_y_max;
         pix_acc <= (skin && (base_cnt != P_MAX)) ? base_cnt + 1'b1 : base_cnt;
         if (vs_rise) begin
            snap_x_min <= x_min;
            snap_x_max <= x_max;
            snap_y_min <= y_min;
            snap_y_max <= y_max;
            snap_cnt   <= pix_acc;
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // FSM next state and publish strobe.
   always_comb begin
      state_d = state_q;
      publish = 1'b0;
      case (state_q)
         IDLE:    if (vs_rise) state_d = ACCUM;
         ACCUM:   if (vs_rise && frame_seen) state_d = PUBLISH;
         PUBLISH: begin
            publish = 1'b1;
            state_d = ACCUM;
         end
         default: state_d = IDLE;
      endcase
   end

   // Published statistics; held until the next publish, zeroed for sparse frames.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vid.box_x_min   <= '0;
         vid.box_x_max   <= '0;
         vid.box_y_min   <= '0;
         vid.box_y_max   <= '0;
         vid.box_pix_cnt <= '0;
         vid.box_valid   <= 1'b0;
         vid.frame_done  <= 1'b0;
      end else begin
         vid.frame_done <= publish;
         if (publish) begin
            if (snap_cnt >= MIN_PIX_W) begin
               vid.box_x_min   <= snap_x_min;
               vid.box_x_max   <= snap_x_max;
               vid.box_y_min   <= snap_y_min;
               vid.box_y_max   <= snap_y_max;
               vid.box_pix_cnt <= snap_cnt;
               vid.box_valid   <= 1'b1;
            end else begin
               vid.box_x_min   <= '0;
               vid.box_x_max   <= '0;
               vid.box_y_min   <= '0;
               vid.box_y_max   <= '0;
               vid.box_pix_cnt <= '0;
               vid.box_valid   <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_ycbcr_skin_bbox.sv
// Scoreboard bench: stimulus pushes expected pixels/boxes, a monitor pops and compares.
module tb_ycbcr_skin_bbox;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   typedef struct {
      int xmin;
      int xmax;
      int ymin;
      int ymax;
      int cnt;
      int valid;
   } box_t;

   int   exp_pix[$];
   box_t exp_box[$];

   logic m_vs, m_hs, m_de;

   ycbcr_skin_bbox_if #(.CW(11)) vid ();

   ycbcr_skin_bbox dut (
      .clk   (clk),
      .rst_n (rst_n),
      .vid   (vid)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Reference 1-cycle delay of the syncs.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_vs <= 1'b0;
         m_hs <= 1'b0;
         m_de <= 1'b0;
      end else begin
         m_vs <= vid.pre_frame_vsync;
         m_hs <= vid.pre_frame_hsync;
         m_de <= vid.pre_frame_de;
      end
   end

   // Monitor: compares whatever the DUT presents against the scoreboard queues.
   always @(negedge clk) begin
      checks++;
      if ({vid.post_frame_vsync, vid.post_frame_hsync, vid.post_frame_de} != {m_vs, m_hs, m_de}) begin
         failures++;
         $display("FAIL syncs: got %b%b%b expected %b%b%b", vid.post_frame_vsync,
                  vid.post_frame_hsync, vid.post_frame_de, m_vs, m_hs, m_de);
      end
      if (vid.post_frame_de) begin
         if (exp_pix.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL pixel: unexpected output %0d, expected none", vid.bin_pixel);
         end else begin
            chk("bin_pixel", int'(vid.bin_pixel), exp_pix.pop_front());
         end
      end else begin
         chk("bin_pixel_idle", int'(vid.bin_pixel), 0);
      end
      if (vid.frame_done) begin
         if (exp_box.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL frame_done: unexpected pulse, expected none");
         end else begin
            box_t e;
            e = exp_box.pop_front();
            checks++;
            if (int'(vid.box_x_min) != e.xmin || int'(vid.box_x_max) != e.xmax ||
                int'(vid.box_y_min) != e.ymin || int'(vid.box_y_max) != e.ymax ||
                int'(vid.box_pix_cnt) != e.cnt || int'(vid.box_valid) != e.valid) begin
               failures++;
               $display("FAIL box: got x %0d..%0d y %0d..%0d cnt %0d valid %0d expected x %0d..%0d y %0d..%0d cnt %0d valid %0d",
                        vid.box_x_min, vid.box_x_max, vid.box_y_min, vid.box_y_max,
                        vid.box_pix_cnt, vid.box_valid,
                        e.xmin, e.xmax, e.ymin, e.ymax, e.cnt, e.valid);
            end
         end
      end
   end

   task automatic drive(input logic vs, input logic de, input logic [7:0] cb,
                        input logic [7:0] cr, input int expv);
      @(posedge clk);
      #1;
      vid.pre_frame_vsync = vs;
      vid.pre_frame_hsync = de;
      vid.pre_frame_de    = de;
      vid.img_y           = 8'h80;
      vid.img_cb          = cb;
      vid.img_cr          = cr;
      if (de) exp_pix.push_back(expv);
   endtask

   task automatic pix(input logic vs, input logic de, input logic skin);
      if (skin) drive(vs, de, 8'd100, 8'd150, 255);
      else      drive(vs, de, 8'd30, 8'd200, 0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) pix(1'b0, 1'b0, 1'b0);
   endtask

   task automatic vsync_rise();
      pix(1'b1, 1'b0, 1'b0);
      pix(1'b1, 1'b0, 1'b0);
      idle(2);
   endtask

   // 16x16 frame, skin inside [rx0..rx1]x[ry0..ry1] except one optional hole.
   task automatic frame(input int rx0, input int rx1, input int ry0, input int ry1,
                        input int hx, input int hy);
      for (int y = 0; y < 16; y++) begin
         for (int x = 0; x < 16; x++)
            pix(1'b0, 1'b1, (x >= rx0 && x <= rx1 && y >= ry0 && y <= ry1 &&
                             !(x == hx && y == hy)));
         idle(2);
      end
   endtask

   function automatic box_t mkbox(input int x0, input int x1, input int y0,
                                  input int y1, input int c, input int v);
      box_t b;
      b.xmin = x0; b.xmax = x1; b.ymin = y0; b.ymax = y1; b.cnt = c; b.valid = v;
      return b;
   endfunction

   initial begin
      vid.pre_frame_vsync = 1'b0;
      vid.pre_frame_hsync = 1'b0;
      vid.pre_frame_de    = 1'b0;
      vid.img_y           = 8'd0;
      vid.img_cb          = 8'd0;
      vid.img_cr          = 8'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_bin", int'(vid.bin_pixel), 0);
      chk("rst_syncs", int'({vid.post_frame_vsync, vid.post_frame_hsync, vid.post_frame_de}), 0);
      chk("rst_box", int'(vid.box_x_min | vid.box_x_max | vid.box_y_min | vid.box_y_max), 0);
      chk("rst_cnt", int'(vid.box_pix_cnt), 0);
      chk("rst_valid_done", int'({vid.box_valid, vid.frame_done}), 0);
      rst_n = 1'b1;
      idle(2);

      // Directed window checks, including both inclusive edges of each bound.
      drive(1'b0, 1'b1, 8'd100, 8'd150, 255);
      drive(1'b0, 1'b1, 8'd76,  8'd150, 0);
      drive(1'b0, 1'b1, 8'd127, 8'd173, 255);
      drive(1'b0, 1'b1, 8'd77,  8'd133, 255);
      drive(1'b0, 1'b1, 8'd128, 8'd150, 0);
      drive(1'b0, 1'b1, 8'd100, 8'd174, 0);
      drive(1'b0, 1'b1, 8'd100, 8'd132, 0);
      drive(1'b0, 1'b0, 8'd100, 8'd150, 0);
      idle(2);

      // First rise publishes nothing; an empty frame publishes zeros.
      vsync_rise();
      frame(1, 0, 1, 0, -1, -1);
      exp_box.push_back(mkbox(0, 0, 0, 0, 0, 0));
      vsync_rise();

      // 64-pixel rectangle.
      frame(3, 10, 2, 9, -1, -1);
      exp_box.push_back(mkbox(3, 10, 2, 9, 64, 1));
      vsync_rise();

      // 63 pixels: below threshold.
      frame(3, 10, 2, 9, 10, 9);
      exp_box.push_back(mkbox(0, 0, 0, 0, 0, 0));
      vsync_rise();

      // Skin pixel coinciding with the vsync rise goes to the new frame at (5,0).
      frame(3, 10, 2, 9, -1, -1);
      for (int i = 0; i < 5; i++) pix(1'b0, 1'b1, 1'b0);
      exp_box.push_back(mkbox(3, 10, 2, 9, 64, 1));
      pix(1'b1, 1'b1, 1'b1);
      pix(1'b1, 1'b0, 1'b0);
      idle(2);
      frame(3, 10, 2, 9, -1, -1);
      exp_box.push_back(mkbox(3, 10, 0, 10, 65, 1));
      vsync_rise();

      // Reset mid-frame while a skin pixel is on the output.
      for (int i = 0; i < 20; i++) pix(1'b0, 1'b1, 1'b1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      vid.pre_frame_de    = 1'b0;
      vid.pre_frame_hsync = 1'b0;
      void'(exp_pix.pop_back());
      #1;
      chk("midrst_bin", int'(vid.bin_pixel), 0);
      chk("midrst_de", int'(vid.post_frame_de), 0);
      chk("midrst_box", int'(vid.box_x_max | vid.box_y_max), 0);
      chk("midrst_cnt_valid", int'(vid.box_pix_cnt) + int'(vid.box_valid), 0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(2);
      vsync_rise();
      frame(0, 7, 0, 7, -1, -1);
      exp_box.push_back(mkbox(0, 7, 0, 7, 64, 1));
      vsync_rise();
      idle(20);

      chk("pix_queue_empty", exp_pix.size(), 0);
      chk("box_queue_empty", exp_box.size(), 0);
      chk("box_hold_xmax", int'(vid.box_x_max), 7);
      chk("box_hold_cnt", int'(vid.box_pix_cnt), 64);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
